// File: rtl/sort_engine.sv
// sort_engine: in-place ascending bubble sort over a word-addressed data memory.
// Reads element count n from SIZE_ADDR, sorts BASE_ADDR..BASE_ADDR+n-1 as
// unsigned words, and exits early after the first pass that makes no swap.
// Every memory control output is registered. A read returns mem_rdata
// combinationally from mem_addr, and a write commits for one cycle.
module sort_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int SIZE_ADDR = 1,
    parameter int BASE_ADDR = 2,
    parameter int MAX_N     = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       swap_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_en,
    output logic              mem_mode,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(SIZE_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] MAX_D  = DATA_W'(MAX_N);
    localparam logic [DATA_W-1:0] TWO_D  = DATA_W'(2);

    typedef enum logic [3:0] {
        IDLE, RD_N, CHK_N, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
    } state_t;

    state_t            state, d_state;
    logic [DATA_W-1:0] n_q, d_n;
    logic [ADDR_W-1:0] i_q, d_i;
    logic [ADDR_W-1:0] j_q, d_j;
    logic [DATA_W-1:0] reg_a, d_a;
    logic [DATA_W-1:0] reg_b, d_b;
    logic              swapped_q, d_swapped;
    logic              d_busy, d_done, d_err;
    logic [15:0]       d_swap;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_we, d_mode;

    // Loop bounds are compared at data width so that n need not be narrowed.
    logic [DATA_W-1:0] i_ext, j_ext, last_j, last_i;

    // Pass and index bounds used by NEXT.
    always_comb begin
        i_ext  = DATA_W'(i_q);
        j_ext  = DATA_W'(j_q);
        last_i = n_q - TWO_D;
        last_j = n_q - TWO_D - i_ext;
    end

    // Next state and next values of every registered output.
    always_comb begin
        d_state   = state;
        d_n       = n_q;
        d_i       = i_q;
        d_j       = j_q;
        d_a       = reg_a;
        d_b       = reg_b;
        d_swapped = swapped_q;
        d_busy    = busy;
        d_done    = done;
        d_err     = err;
        d_swap    = swap_count;
        d_addr    = mem_addr;
        d_wdata   = mem_wdata;
        d_we      = 1'b0;
        d_mode    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    d_done  = 1'b0;
                    d_err   = 1'b0;
                    d_swap  = '0;
                    d_busy  = 1'b1;
                    d_addr  = SIZE_A;
                    d_state = RD_N;
                end
            end
            RD_N: begin
                d_n     = mem_rdata;
                d_state = CHK_N;
            end
            CHK_N: begin
                if (n_q < TWO_D) begin
                    d_busy  = 1'b0;
                    d_done  = 1'b1;
                    d_state = DONE;
                end else begin
                    if (n_q > MAX_D) begin
                        d_n   = MAX_D;
                        d_err = 1'b1;
                    end
                    d_i       = '0;
                    d_j       = '0;
                    d_swapped = 1'b0;
                    d_addr    = BASE_A;
                    d_state   = RD_A;
                end
            end
            RD_A: begin
                d_a     = mem_rdata;
                d_addr  = BASE_A + j_q + ONE_A;
                d_state = RD_B;
            end
            RD_B: begin
                d_b     = mem_rdata;
                d_state = CMP;
            end
            CMP: begin
                if (reg_a > reg_b) begin
                    if (swap_count != '1) begin
                        d_swap = swap_count + 16'd1;
                    end
                    d_addr  = BASE_A + j_q;
                    d_wdata = reg_b;
                    d_we    = 1'b1;
                    d_mode  = 1'b1;
                    d_state = WR_A;
                end else begin
                    d_state = NEXT;
                end
            end
            WR_A: begin
                d_addr  = BASE_A + j_q + ONE_A;
                d_wdata = reg_a;
                d_we    = 1'b1;
                d_mode  = 1'b1;
                d_state = WR_B;
            end
            WR_B: begin
                d_swapped = 1'b1;
                d_state   = NEXT;
            end
            NEXT: begin
                if (j_ext < last_j) begin
                    d_j     = j_q + ONE_A;
                    d_addr  = BASE_A + j_q + ONE_A;
                    d_state = RD_A;
                end else if (!swapped_q || i_ext == last_i) begin
                    d_busy  = 1'b0;
                    d_done  = 1'b1;
                    d_state = DONE;
                end else begin
                    d_i       = i_q + ONE_A;
                    d_j       = '0;
                    d_swapped = 1'b0;
                    d_addr    = BASE_A;
                    d_state   = RD_A;
                end
            end
            DONE: begin
                d_state = IDLE;
            end
            default: begin
                d_state = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any sort in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            n_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            reg_a        <= '0;
            reg_b        <= '0;
            swapped_q    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            swap_count   <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_write_en <= 1'b0;
            mem_mode     <= 1'b0;
        end else begin
            state        <= d_state;
            n_q          <= d_n;
            i_q          <= d_i;
            j_q          <= d_j;
            reg_a        <= d_a;
            reg_b        <= d_b;
            swapped_q    <= d_swapped;
            busy         <= d_busy;
            done         <= d_done;
            err          <= d_err;
            swap_count   <= d_swap;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            mem_write_en <= d_we;
            mem_mode     <= d_mode;
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed, table-driven bench for sort_engine with a 32-word
// behavioural data memory. Edge counts are measured from the edge that accepts
// start (counted as 1) up to the edge after which done is first seen high.
module tb_sort_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err;
    logic [15:0] swap_count;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_write_en, mem_mode;

    always #5 clk = ~clk;

    sort_engine #(
        .DATA_W(32), .ADDR_W(5), .SIZE_ADDR(1), .BASE_ADDR(2), .MAX_N(30)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err(err), .swap_count(swap_count), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
        .mem_mode(mem_mode), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write on the edge while write_en & mode.
    logic [31:0] mem [32];
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        clr_stats = 1'b0;
    int unsigned wr_cnt = 0, oob_cnt = 0;
    int unsigned wr_lo = 2, wr_hi = 31;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_write_en && mem_mode) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (clr_stats) begin
            wr_cnt  <= 0;
            oob_cnt <= 0;
        end else if (mem_write_en && mem_mode) begin
            wr_cnt <= wr_cnt + 1;
            if (int'(mem_addr) < int'(wr_lo) || int'(mem_addr) > int'(wr_hi))
                oob_cnt <= oob_cnt + 1;
        end
    end

    int unsigned tests = 0, fails = 0;
    int unsigned edges;
    logic        tmo;
    logic [31:0] img [32];

    typedef struct packed {
        logic [31:0]       n;
        logic [0:9][31:0]  din;
        logic [0:9][31:0]  dexp;
        logic [15:0]       swaps;
        logic              err;
        logic [15:0]       edges;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [0:9][31:0] p10(
        input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        return {a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_image();
        clr_stats = 1'b1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 5'(a);
            ld_data = img[a];
        end
        @(negedge clk);
        ld_en     = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        tmo = 1'b0;
        while (!done && !tmo) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges > bound) tmo = 1'b1;
        end
        check("done_within_bound", {31'd0, tmo}, 32'd0);
    endtask

    task automatic run_sort(input int unsigned bound);
        pulse_start();
        edges = 1;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        wait_done(bound);
    endtask

    task automatic fill_default();
        for (int a = 0; a < 32; a++) img[a] = 32'hA5A5_0000 | 32'(a);
        img[1] = vecs[0].n;
        for (int k = 0; k < 10; k++) img[2+k] = vecs[0].din[k];
        wr_lo = 2;
        wr_hi = 11;
    endtask

    task automatic check_default_sorted(input string tag);
        for (int k = 0; k < 10; k++) check({tag, "_word"}, mem[2+k], vecs[0].dexp[k]);
        check({tag, "_swaps"}, {16'd0, swap_count}, 32'd22);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_oob"}, oob_cnt, 32'd0);
    endtask

    initial begin
        // Hand-computed vectors; edges = 3 setup + 4 per plain compare + 6 per swap.
        vecs[0].n = 10;
        vecs[0].din  = p10(2, 3, 2, 2, 6, 1, 4, 3, 2, 1);
        vecs[0].dexp = p10(1, 1, 2, 2, 2, 2, 3, 3, 4, 6);
        vecs[0].swaps = 22; vecs[0].err = 1'b0; vecs[0].edges = 227;   // 45 compares, 22 swaps
        vecs[1].n = 10;
        vecs[1].din  = p10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        vecs[1].dexp = p10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        vecs[1].swaps = 0; vecs[1].err = 1'b0; vecs[1].edges = 39;     // 40th cycle incl. start
        vecs[2].n = 0;
        vecs[2].din  = p10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
        vecs[2].dexp = p10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
        vecs[2].swaps = 0; vecs[2].err = 1'b0; vecs[2].edges = 3;
        vecs[3].n = 1;
        vecs[3].din  = p10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
        vecs[3].dexp = p10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
        vecs[3].swaps = 0; vecs[3].err = 1'b0; vecs[3].edges = 3;
        vecs[4].n = 5;
        vecs[4].din  = p10(5, 4, 3, 2, 1, 50, 40, 30, 20, 10);
        vecs[4].dexp = p10(1, 2, 3, 4, 5, 50, 40, 30, 20, 10);
        vecs[4].swaps = 10; vecs[4].err = 1'b0; vecs[4].edges = 63;
        vecs[5].n = 2;
        vecs[5].din  = p10(7, 3, 1, 1, 1, 1, 1, 1, 1, 1);
        vecs[5].dexp = p10(3, 7, 1, 1, 1, 1, 1, 1, 1, 1);
        vecs[5].swaps = 1; vecs[5].err = 1'b0; vecs[5].edges = 9;
        vecs[6].n = 2;
        vecs[6].din  = p10(5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6].dexp = p10(5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6].swaps = 0; vecs[6].err = 1'b0; vecs[6].edges = 7;
        vecs[7].n = 3;
        vecs[7].din  = p10(32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
        vecs[7].dexp = p10(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
        vecs[7].swaps = 2; vecs[7].err = 1'b0; vecs[7].edges = 19;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_swaps", {16'd0, swap_count}, 32'd0);
        check("rst_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_we", {31'd0, mem_write_en}, 32'd0);
        check("rst_mode", {31'd0, mem_mode}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven sorts.
        for (int v = 0; v < 8; v++) begin
            for (int a = 0; a < 32; a++) img[a] = 32'hA5A5_0000 | 32'(a);
            img[1] = vecs[v].n;
            for (int k = 0; k < 10; k++) img[2+k] = vecs[v].din[k];
            wr_lo = 2;
            wr_hi = 1 + vecs[v].n;
            load_image();
            run_sort(5000);
            check("swap_count", {16'd0, swap_count}, {16'd0, vecs[v].swaps});
            check("err", {31'd0, err}, {31'd0, vecs[v].err});
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("done_edges", edges, {16'd0, vecs[v].edges});
            check("write_count", wr_cnt, 2 * {16'd0, vecs[v].swaps});
            check("write_oob", oob_cnt, 32'd0);
            check("size_word", mem[1], vecs[v].n);
            for (int k = 0; k < 10; k++) check("array_word", mem[2+k], vecs[v].dexp[k]);
            @(posedge clk);
            #1;
            check("done_held_idle", {31'd0, done}, 32'd1);
        end

        // n = 40 is clamped to 30: reverse-ordered words at 2..31.
        for (int a = 0; a < 32; a++) img[a] = 1000 - a;
        img[0] = 32'h1234_5678;
        img[1] = 40;
        wr_lo = 2;
        wr_hi = 31;
        load_image();
        run_sort(5000);
        check("clamp_err", {31'd0, err}, 32'd1);
        check("clamp_swaps", {16'd0, swap_count}, 32'd435);
        check("clamp_edges", edges, 32'd2613);
        check("clamp_oob", oob_cnt, 32'd0);
        check("clamp_word0", mem[0], 32'h1234_5678);
        check("clamp_word1", mem[1], 32'd40);
        for (int k = 0; k < 30; k++) check("clamp_sorted", mem[2+k], 32'(969 + k));

        // Asynchronous reset during the first WR_A of the default sort.
        fill_default();
        load_image();
        pulse_start();
        edges = 1;
        tmo   = 1'b0;
        while (!mem_write_en && !tmo) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges > 200) tmo = 1'b1;
        end
        check("reach_wr_a", {31'd0, tmo}, 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_swaps", {16'd0, swap_count}, 32'd0);
        check("midrst_addr", {27'd0, mem_addr}, 32'd0);
        check("midrst_wdata", mem_wdata, 32'd0);
        check("midrst_we", {31'd0, mem_write_en}, 32'd0);
        check("midrst_mode", {31'd0, mem_mode}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // The aborted write never committed, so the array is still the original.
        for (int k = 0; k < 10; k++) check("midrst_untouched", mem[2+k], vecs[0].din[k]);
        run_sort(5000);
        check_default_sorted("after_rst");

        // A second start while busy changes nothing.
        fill_default();
        load_image();
        pulse_start();
        edges = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            edges++;
        end
        pulse_start();
        edges++;
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(5000);
        check_default_sorted("restart");
        check("restart_edges", edges, 32'd227);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
